// File: rtl/channel_fifo_if.sv
// ---------------------------------------------------------------------------
// channel_fifo_if
// Groups the two en/ack channels of channel_fifo into one bundle.
//
//   channel_in_data   upstream word, held stable while channel_in_en=1
//   channel_in_en     upstream word-offered flag
//   channel_in_ack    one-cycle accept pulse back to upstream
//   channel_out_data  head word offered downstream
//   channel_out_en    downstream word-offered flag
//   channel_out_ack   downstream accept pulse
//
// Modports:
//   master  the surroundings of the FIFO (upstream producer and
//           downstream consumer together)
//   slave   the FIFO itself
// ---------------------------------------------------------------------------
interface channel_fifo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] channel_in_data;
  logic             channel_in_en;
  logic             channel_in_ack;
  logic [WIDTH-1:0] channel_out_data;
  logic             channel_out_en;
  logic             channel_out_ack;

  modport master (
    output channel_in_data,
    output channel_in_en,
    input  channel_in_ack,
    input  channel_out_data,
    input  channel_out_en,
    output channel_out_ack
  );

  modport slave (
    input  channel_in_data,
    input  channel_in_en,
    output channel_in_ack,
    output channel_out_data,
    output channel_out_en,
    input  channel_out_ack
  );
endinterface

// File: rtl/channel_fifo.sv
// ---------------------------------------------------------------------------
// channel_fifo
// Elastic buffer between two en/ack channel stages. The block is the
// consumer on the input channel and the producer on the output channel.
//
// Parameters:
//   WIDTH  data width of both channels
//   DEPTH  number of storage entries (power of two, >= 2)
//
// Ports:
//   clk    sole clock, all state updates on the rising edge
//   rst    asynchronous active-high reset
//   ch     channel bundle (slave side), see channel_fifo_if
//   level  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  channel_fifo_if.slave          ch,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = '0;
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // The output channel is either idle (en low) or offering the head word.
  typedef enum logic {
    OUT_IDLE,
    OUT_OFFER
  } out_state_t;

  out_state_t       out_state;
  out_state_t       out_state_next;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             in_ack_q;
  logic [WIDTH-1:0] out_data_q;
  logic             push;
  logic             pop;
  logic             load;

  // A push needs a fresh offer: gating on our own registered ack stops the
  // word that is just being acknowledged from being stored a second time,
  // and keeps the ack from ever lasting two cycles. The full test uses the
  // level before the edge, so a pop at the same edge does not open a slot.
  assign push = ch.channel_in_en && !in_ack_q && (count != LVL_FULL);

  // Output-side next state. A word is offered from idle whenever something
  // is stored; an accepted offer always returns to idle, which yields the
  // mandatory one low cycle of channel_out_en between words. An ack seen
  // while idle falls through untouched.
  always_comb begin
    out_state_next = out_state;
    load           = 1'b0;
    pop            = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (count != LVL_ZERO) begin
          out_state_next = OUT_OFFER;
          load           = 1'b1;
        end
      end
      OUT_OFFER: begin
        if (ch.channel_out_ack) begin
          out_state_next = OUT_IDLE;
          pop            = 1'b1;
        end
      end
      default: begin
        out_state_next = OUT_IDLE;
      end
    endcase
  end

  // Output-side state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state <= OUT_IDLE;
    end else begin
      out_state <= out_state_next;
    end
  end

  // Pointers, occupancy, input ack and the offered output word. Reset
  // throws away every stored word and any pending offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ack_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      in_ack_q <= push;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (load) begin
        out_data_q <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + LVL_ONE;
      end else if (pop && !push) begin
        count <= count - LVL_ONE;
      end
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ch.channel_in_data;
    end
  end

  assign ch.channel_in_ack   = in_ack_q;
  assign ch.channel_out_en   = (out_state == OUT_OFFER);
  assign ch.channel_out_data = out_data_q;
  assign level               = count;
endmodule
